// File: rtl/nanorv32_tcm_dbg_arbiter.sv
// nanorv32 data TCM arbiter: CPU port m0 has fixed priority, debug port m1
// gets the TCM after at most MAX_WAIT m0 grants while it is pending.
module nanorv32_tcm_dbg_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [31:0]           m0_addr,
  input  logic                  m0_write,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_bytesel,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic [31:0]           m1_addr,
  input  logic                  m1_write,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_bytesel,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  tcm_en,
  output logic [ADDR_WIDTH-1:0] tcm_addr,
  output logic [31:0]           tcm_din,
  output logic [3:0]            tcm_bytesel,
  input  logic [31:0]           tcm_dout,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE, ACC0, ACC1, RESP0, RESP1
  } state_t;

  localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

  state_t                  state_q, state_d;
  logic [7:0]              wait_cnt_q, wait_cnt_d;
  logic                    tcm_en_q, tcm_en_d;
  logic [ADDR_WIDTH-1:0]   tcm_addr_q, tcm_addr_d;
  logic [31:0]             tcm_din_q, tcm_din_d;
  logic [3:0]              tcm_bytesel_q, tcm_bytesel_d;
  logic                    arb, cand0, cand1, win0, win1;

  logic unused_addr;
  assign unused_addr = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                         m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      tcm_en_q      <= 1'b0;
      tcm_addr_q    <= '0;
      tcm_din_q     <= '0;
      tcm_bytesel_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      tcm_en_q      <= tcm_en_d;
      tcm_addr_q    <= tcm_addr_d;
      tcm_din_q     <= tcm_din_d;
      tcm_bytesel_q <= tcm_bytesel_d;
    end
  end

  // The master completing in RESPx is masked so the other one gets a turn.
  always_comb begin
    arb   = (state_q == IDLE) || (state_q == RESP0) || (state_q == RESP1);
    cand0 = arb && m0_req && (state_q != RESP0);
    cand1 = arb && m1_req && (state_q != RESP1);
    win1  = cand1 && (!cand0 || (wait_cnt_q == MAX_W));
    win0  = cand0 && !win1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC0:    state_d = RESP0;
      ACC1:    state_d = RESP1;
      default: begin
        if (win1)      state_d = ACC1;
        else if (win0) state_d = ACC0;
        else           state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    tcm_en_d      = 1'b0;
    tcm_addr_d    = '0;
    tcm_din_d     = '0;
    tcm_bytesel_d = '0;
    if (win0) begin
      tcm_en_d      = 1'b1;
      tcm_addr_d    = m0_addr[ADDR_WIDTH+1:2];
      tcm_din_d     = m0_wdata;
      tcm_bytesel_d = m0_write ? m0_bytesel : 4'b0000;
    end else if (win1) begin
      tcm_en_d      = 1'b1;
      tcm_addr_d    = m1_addr[ADDR_WIDTH+1:2];
      tcm_din_d     = m1_wdata;
      tcm_bytesel_d = m1_write ? m1_bytesel : 4'b0000;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m1_req || win1)
      wait_cnt_d = '0;
    else if (win0 && (wait_cnt_q < MAX_W))
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_comb begin
    m0_ready    = (state_q == RESP0);
    m1_ready    = (state_q == RESP1);
    m0_rdata    = m0_ready ? tcm_dout : 32'h0;
    m1_rdata    = m1_ready ? tcm_dout : 32'h0;
    busy        = (state_q != IDLE);
    tcm_en      = tcm_en_q;
    tcm_addr    = tcm_addr_q;
    tcm_din     = tcm_din_q;
    tcm_bytesel = tcm_bytesel_q;
  end

endmodule
